clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised multi-channel programmable clock divider; successor to the fixed-ratio single-output divider.
- Generates N independent divided clocks (registered, glitch-free) from I_CLK.
- Each channel has a runtime-programmable divisor, graceful enable/disable and a period-start tick.
- A global sync input phase-aligns channels.
- Feeds peripheral timing (UART/PWM/scan) in the same clock domain.

Parameters:
- N_CH, 4, number of output channels (1..16).
- DIV_W, 16, divisor/counter width in bits.
- DEF_DIV, 10, divisor loaded into every channel at reset (must be >=2).

Ports:
- I_CLK  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  N_CH  per-channel run enable, level.
- sync  in  1  one-cycle pulse; restarts all enabled channels in phase.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  max(1,$clog2(N_CH))  target channel for cfg_we.
- cfg_div  in  DIV_W  new divisor.
- cfg_pending  out  N_CH  shadow divisor written but not yet applied.
- O_CLK  out  N_CH  divided clocks, registered.
- O_TICK  out  N_CH  one-cycle pulse on the first cycle of each output period.

Behaviour:
- Reset (rst=0, async):
  - O_CLK=0, O_TICK=0, cfg_pending=0.
  - Per channel: cnt=0, running=0, active divisor D=DEF_DIV, shadow=DEF_DIV.
- Divisor rules:
  - H = (D+1)>>1, i.e. O_CLK high for ceil(D/2) cycles and low for floor(D/2) cycles.
  - Period is exactly D I_CLK cycles.
  - cfg_div<2 is clamped to 2.
  - All arithmetic is DIV_W bits, with no overflow since cnt<=D-1.
- Per-channel state: IDLE (running=0) or RUN (running=1).
- IDLE:
  - O_CLK=0, O_TICK=0.
  - An edge with en=1 gives cnt<=0, O_CLK<=1, O_TICK<=1, ->RUN.
  - Latency from en sampled high to O_CLK high: 1 cycle.
- RUN, each edge:
  - cnt_next = (cnt==D-1) ? 0 : cnt+1.
  - O_CLK <= (cnt_next < H).
  - O_TICK <= (cnt_next==0).
- Wrap edge (cnt==D-1):
  - If en=0: ->IDLE, O_CLK<=0, cnt<=0, O_TICK<=0. The current period always completes, so there are no runt pulses.
  - If pending: D<=shadow, pending<=0. The new period uses the new D.
- Deasserting then reasserting en before the wrap has no effect; the channel keeps running.
- Configuration writes:
  - cfg_we with cfg_ch>=N_CH is ignored.
  - cfg_we to a RUN channel: shadow<=clamp(cfg_div), pending<=1, applied at that channel's next wrap.
  - cfg_we on the wrap edge itself: the value goes to the shadow and is applied at the following wrap, not the current one.
  - Repeated writes while pending: last write wins.
  - cfg_we to an IDLE channel: D and shadow updated next edge; pending stays 0.
- sync=1 on an edge:
  - Every channel with en=1 (IDLE or RUN) does cnt<=0, O_CLK<=1, O_TICK<=1, running<=1.
  - A pending shadow is applied at the same time.
  - Channels with en=0 ignore sync and keep their graceful-stop behaviour.
  - sync takes priority over the normal wrap/increment.
- sync and cfg_we on the same edge: sync applies the old shadow; the new write becomes pending.
- Reset mid-period: immediate return to the reset state; O_CLK drops asynchronously.
- Outputs are pure flops, with no combinational path to O_CLK.

Decomposition:
- Shared package/include:
  - DIV_W default, DEF_DIV, MIN_DIV=2.
  - Clamp function.
  - Half-period function H(D).
- Sub-module clk_div_chan: one channel containing cnt, D, shadow, pending, running, O_CLK and O_TICK.
- Top clk_div_multi: decodes cfg_ch into a per-channel write strobe, fans out sync, and instantiates N_CH channels with a generate loop.

Test Plan:
- Reset release with en=4'b0001 and defaults: ch0 O_CLK shows 5 high / 5 low, period 10 cycles. The first high begins 1 cycle after en is sampled. O_TICK fires every 10 cycles. Other channels stay 0.
- cfg_ch=1, cfg_div=3, then en[1]=1: O_CLK[1] is 2 high / 1 low. cfg_div=7 gives 4 high / 3 low (odd divisors). cfg_div=0 and cfg_div=1 both behave as D=2 (1 high / 1 low).
- ch0 running at D=10; write cfg_div=4 at cnt=3: cfg_pending[0]=1 until the wrap. The current period stays 10 cycles, then periods become 4 cycles and pending clears. A write landing on the wrap edge is applied one period later.
- ch2 running at D=8; drop en[2] at cnt=1: the period completes (4 high, 4 low), then O_CLK stays 0 and O_TICK stays 0. Re-asserting en gives a high output 1 cycle later.
- ch0 at D=6 and ch1 at D=9 both enabled; pulse sync: both show O_CLK=1 and O_TICK=1 on the next cycle with cnt=0. Their edges realign every 18 cycles.
- Assert rst=0 mid-high phase (asynchronous, between clock edges): all O_CLK=0 immediately. After release, D is back to 10 regardless of earlier writes.

Source files
------------

// File: rtl/clk_div_multi_pkg.sv
// clk_div_multi_pkg: shared defaults and divisor helpers for the multi-channel clock divider.
package clk_div_multi_pkg;
    localparam int DIV_W_DEF   = 16;
    localparam int DEF_DIV_DEF = 10;
    localparam int MIN_DIV     = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
    endfunction

    // High phase length ceil(D/2), widened so D near full scale cannot wrap
    function automatic logic [31:0] half_div(input logic [31:0] d);
        return 32'(({1'b0, d} + 33'd1) >> 1);
    endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one programmable divider channel with shadowed divisor and graceful stop.
module clk_div_chan
    import clk_div_multi_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [DIV_W-1:0] wdata,
    output logic             div_clk,
    output logic             tick,
    output logic             pending
);
    logic [DIV_W-1:0] cnt, d, shadow, cnt_inc, h, cw;
    logic running, wrap, start, restart, to_shadow;

    assign cnt_inc   = cnt + 1'b1;
    assign h         = DIV_W'(half_div(32'(d)));
    assign cw        = DIV_W'(clamp_div(32'(wdata)));
    assign wrap      = running && (cnt == d - 1'b1);
    assign start     = en && (sync || !running);
    assign restart   = start || wrap;
    // A write lands in the shadow whenever the channel is, or is about to be, running under sync
    assign to_shadow = running || (sync && en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            d       <= DIV_W'(DEF_DIV);
            shadow  <= DIV_W'(DEF_DIV);
            pending <= 1'b0;
            running <= 1'b0;
            div_clk <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (restart) begin
                cnt     <= '0;
                div_clk <= en;
                tick    <= en;
                running <= en;
            end else if (running) begin
                cnt     <= cnt_inc;
                div_clk <= cnt_inc < h;
                tick    <= 1'b0;
            end
            if (we && to_shadow) begin
                shadow  <= cw;
                pending <= 1'b1;
                if (restart && pending) d <= shadow;
            end else if (we) begin
                d       <= cw;
                shadow  <= cw;
                pending <= 1'b0;
            end else if (restart && pending) begin
                d       <= shadow;
                pending <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N independent programmable clock dividers with shared sync and config bus.
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF,
    localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             I_CLK,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [N_CH-1:0]  cfg_pending,
    output logic [N_CH-1:0]  O_CLK,
    output logic [N_CH-1:0]  O_TICK
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Out-of-range channel numbers match no instance and are dropped
        clk_div_chan #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_chan (
            .clk     (I_CLK),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync),
            .we      (cfg_we && (cfg_ch == CW'(i))),
            .wdata   (cfg_div),
            .div_clk (O_CLK[i]),
            .tick    (O_TICK[i]),
            .pending (cfg_pending[i])
        );
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed and random stimulus checked against a period-position reference model.
module tb_clk_div_multi;
    localparam int N = 5;
    localparam int W = 16;

    logic         I_CLK = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] en = '0;
    logic         sync = 1'b0;
    logic         cfg_we = 1'b0;
    logic [2:0]   cfg_ch = '0;
    logic [W-1:0] cfg_div = '0;
    logic [N-1:0] cfg_pending, O_CLK, O_TICK;

    int checks = 0;
    int failures = 0;

    int m_d[N], m_sh[N], m_pos[N];
    bit m_run[N], m_pend[N];

    clk_div_multi #(.N_CH(N), .DIV_W(W), .DEF_DIV(10)) dut (
        .I_CLK(I_CLK), .rst(rst), .en(en), .sync(sync), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_pending(cfg_pending),
        .O_CLK(O_CLK), .O_TICK(O_TICK)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_d[c] = 10; m_sh[c] = 10; m_pos[c] = 0; m_run[c] = 0; m_pend[c] = 0;
        end
    endtask

    // Each channel is a position inside a D-cycle period; output is high for the first ceil(D/2) positions
    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            bit w, was, wrap, st;
            int cw;
            w    = cfg_we && (int'(cfg_ch) == c);
            cw   = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
            was  = m_run[c];
            wrap = was && (m_pos[c] == m_d[c] - 1);
            st   = en[c] && (sync || !was);
            if (st || wrap) begin
                if (m_pend[c]) begin m_d[c] = m_sh[c]; m_pend[c] = 0; end
                m_pos[c] = 0;
                m_run[c] = en[c];
            end else if (was) m_pos[c]++;
            if (w) begin
                if (was || (sync && en[c])) begin m_sh[c] = cw; m_pend[c] = 1; end
                else begin m_d[c] = cw; m_sh[c] = cw; m_pend[c] = 0; end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] e_clk, e_tick, e_pend;
        for (int c = 0; c < N; c++) begin
            e_clk[c]  = m_run[c] && (m_pos[c] < (m_d[c] + 1) / 2);
            e_tick[c] = m_run[c] && (m_pos[c] == 0);
            e_pend[c] = m_pend[c];
        end
        checks += 3;
        assert (O_CLK === e_clk) else begin
            failures++; $error("FAIL %s O_CLK obs=%b exp=%b t=%0t", tag, O_CLK, e_clk, $time);
        end
        assert (O_TICK === e_tick) else begin
            failures++; $error("FAIL %s O_TICK obs=%b exp=%b t=%0t", tag, O_TICK, e_tick, $time);
        end
        assert (cfg_pending === e_pend) else begin
            failures++; $error("FAIL %s cfg_pending obs=%b exp=%b t=%0t", tag, cfg_pending, e_pend, $time);
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge I_CLK);
        #1;
        check_all(tag);
        cfg_we = 1'b0;
        sync = 1'b0;
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) step(tag);
    endtask

    task automatic write(input int ch, input int div);
        cfg_ch = 3'(ch); cfg_div = W'(div); cfg_we = 1'b1;
    endtask

    task automatic expect_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++; $error("FAIL %s obs=%b exp=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge I_CLK);
        #1;
        check_all("reset");
        rst = 1'b1;
        run(3, "idle");

        en = 5'b00001;
        step("start0");
        expect_bit("latency0", O_CLK[0], 1'b1);
        run(25, "ch0_def");

        write(1, 3); step("cfg1_3");
        en[1] = 1'b1; run(12, "ch1_d3");
        write(1, 7); run(25, "ch1_d7");
        write(1, 0); run(20, "ch1_d0");
        write(1, 1); run(20, "ch1_d1");
        write(5, 4); step("ignored5");
        write(7, 9); run(25, "ignored7");

        for (int k = 0; k < 40 && m_pos[0] != 3; k++) step("seek0");
        write(0, 4); step("cfg0_mid");
        expect_bit("pend0", cfg_pending[0], 1'b1);
        run(30, "ch0_d4");
        for (int k = 0; k < 40 && m_pos[0] != m_d[0] - 1; k++) step("seek_wrap");
        write(0, 6); run(20, "cfg_on_wrap");

        write(2, 8); step("cfg2_idle");
        en[2] = 1'b1; step("start2");
        en[2] = 1'b0; run(15, "ch2_stop");
        en[2] = 1'b1; step("restart2");
        expect_bit("relat2", O_CLK[2], 1'b1);
        run(10, "ch2_run");

        write(0, 6); step("w0");
        write(1, 9); step("w1");
        en = 5'b00011; sync = 1'b1; step("sync");
        expect_bit("sync_tick0", O_TICK[0], 1'b1);
        expect_bit("sync_tick1", O_TICK[1], 1'b1);
        write(0, 5); sync = 1'b1; step("sync_cfg");
        run(40, "aligned");

        for (int k = 0; k < 40 && !(m_run[0] && m_pos[0] < (m_d[0] + 1) / 2); k++) step("seek_high");
        #2 rst = 1'b0;
        #1;
        expect_bit("async_clk_low", |O_CLK, 1'b0);
        expect_bit("async_pend_low", |cfg_pending, 1'b0);
        model_reset();
        @(posedge I_CLK);
        #1;
        check_all("in_reset");
        rst = 1'b1;
        en = 5'b00001;
        run(25, "post_reset");

        repeat (3000) begin
            if ($urandom_range(0, 39) == 0) en = N'($urandom);
            if ($urandom_range(0, 7) == 0) write(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)));
            if ($urandom_range(0, 59) == 0) sync = 1'b1;
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
